// File: rtl/dtw_pkg.sv
// Shared types for the DTW query path: sequencer states and score limits.
package dtw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PRIME,
        RUN,
        CAPTURE,
        RESULT
    } state_t;

    localparam logic [63:0] DTW_SCORE_MAX = '1;

endpackage

// File: rtl/dtw_query_sequencer.sv
// Runs one query through dtw_core_datapath: clear, prime, stream, latch,
// then hands minval/position out on a valid/ready result port.
import dtw_pkg::*;

module dtw_query_sequencer #(
    parameter int width    = 16,
    parameter int SQG_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       ref_len_in,
    output logic              busy,
    input  logic              sqg_valid,
    output logic              sqg_ready,
    input  logic [width-1:0]  sqg_data,
    input  logic              ref_valid,
    output logic              ref_ready,
    input  logic [width-1:0]  ref_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [width-1:0]  res_minval,
    output logic [31:0]       res_position,
    output logic              dp_rst,
    output logic              dp_running,
    output logic [width-1:0]  dp_squiggle,
    output logic [width-1:0]  dp_rword,
    output logic [31:0]       dp_ref_len,
    input  logic [width-1:0]  dp_minval,
    input  logic [31:0]       dp_position,
    input  logic              dp_done
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] len_q;
    logic [31:0] sqg_cnt;
    logic [31:0] ref_cnt;
    logic        sqg_need;
    logic        ref_need;
    logic        fire;
    logic        in_run;
    logic        kill;
    logic        launch;

    assign in_run   = (state == RUN);
    assign kill     = abort & (state != IDLE);
    assign launch   = (state == IDLE) & start;
    assign sqg_need = sqg_cnt < 32'(SQG_SIZE);
    assign ref_need = ref_cnt < len_q;
    assign fire     = (~sqg_need | sqg_valid) & (~ref_need | ref_valid);

    // An exhausted stream is padded with zeros, so it never holds up fire.
    assign sqg_ready  = in_run & ~kill & fire & sqg_need;
    assign ref_ready  = in_run & ~kill & fire & ref_need;
    assign dp_running = ~kill & ((state == PRIME) |
                                 (in_run & (fire | dp_done)));

    assign dp_squiggle = sqg_ready ? sqg_data : '0;
    assign dp_rword    = ref_ready ? ref_data : '0;
    assign dp_ref_len  = len_q;
    assign dp_rst      = ~rst_n | (state == CLEAR);
    assign busy        = (state != IDLE);
    assign res_valid   = (state == RESULT);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = (ref_len_in != '0) ? CLEAR : RESULT;
            end
            CLEAR:   state_nxt = PRIME;
            PRIME:   state_nxt = RUN;
            RUN:     if (dp_done) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_q        <= '0;
            sqg_cnt      <= '0;
            ref_cnt      <= '0;
            res_minval   <= DTW_SCORE_MAX[width-1:0];
            res_position <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                if (ref_len_in != '0) begin
                    len_q   <= ref_len_in;
                    sqg_cnt <= '0;
                    ref_cnt <= '0;
                end else begin
                    res_minval   <= DTW_SCORE_MAX[width-1:0];
                    res_position <= '0;
                end
            end
            if (sqg_ready)
                sqg_cnt <= sqg_cnt + 32'd1;
            if (ref_ready)
                ref_cnt <= ref_cnt + 32'd1;
            if ((state == CAPTURE) && !kill) begin
                res_minval   <= dp_minval;
                res_position <= dp_position;
            end
        end
    end

endmodule
